uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N_REQ requesters using round-robin arbitration.
- Captures the granted requester's byte, then drives tx_data and tx_valid to the transmitter.
- Holds tx_valid high for the whole frame until the transmitter pulses tx_done.
- Inserts a programmable idle guard between frames and aborts a frame with an error pulse if tx_done never arrives.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ
// requesters. The winner's byte is captured and presented with tx_valid until
// the transmitter reports tx_done. A forced idle gap follows each frame, and a
// frame that never completes is aborted with a one-cycle err_timeout.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrating; a request at the edge starts a frame
//   SEND  | tx_valid high, tx_data held, waiting for tx_done or timeout
//   GAP   | forced idle between frames, requests and tx_done ignored
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_done,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ID_W:0]    N_L      = (ID_W + 1)'(N_REQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state, state_nx;
  logic [ID_W-1:0]       ptr, ptr_nx;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nx;
  logic [TO_W-1:0]       to_cnt, to_cnt_nx;
  logic [N_REQ-1:0]      req_ready_nx;
  logic [DATA_WIDTH-1:0] tx_data_nx;
  logic                  tx_valid_nx;
  logic [ID_W-1:0]       grant_nx;
  logic                  busy_nx;
  logic                  err_nx;

  logic [ID_W-1:0]       win;
  logic                  found;
  logic [ID_W:0]         sum;
  logic [ID_W:0]         ptr_inc;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (sum >= N_L) sum = sum - N_L;
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  // Winner's byte and the pointer position just past the winner.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win) sel_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    ptr_inc = {1'b0, win} + (ID_W + 1)'(1);
    if (ptr_inc == N_L) ptr_inc = '0;
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    gap_cnt_nx   = gap_cnt;
    to_cnt_nx    = to_cnt;
    tx_valid_nx  = tx_valid;
    tx_data_nx   = tx_data;
    grant_nx     = grant_id;
    req_ready_nx = '0;
    err_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx     = SEND;
          tx_valid_nx  = 1'b1;
          tx_data_nx   = sel_data;
          grant_nx     = win;
          req_ready_nx = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          ptr_nx       = ptr_inc[ID_W-1:0];
          to_cnt_nx    = TO_W'(1);
        end
      end
      SEND: begin
        // tx_done takes precedence over a timeout landing on the same edge
        if (tx_done || (to_cnt == TO_LAST)) begin
          tx_valid_nx = 1'b0;
          err_nx      = !tx_done;
          to_cnt_nx   = '0;
          if (GAP_CYCLES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx   = GAP;
            gap_cnt_nx = GAP_LOAD;
          end
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nx = IDLE;
        else               gap_cnt_nx = gap_cnt - GAP_W'(1);
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State, counters and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      req_ready   <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      gap_cnt     <= gap_cnt_nx;
      to_cnt      <= to_cnt_nx;
      req_ready   <= req_ready_nx;
      tx_data     <= tx_data_nx;
      tx_valid    <= tx_valid_nx;
      grant_id    <= grant_nx;
      busy        <= busy_nx;
      err_timeout <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Three instances cover the default
// configuration (a), a short timeout with a small gap (b) and a zero gap (c).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  a_req_valid, a_req_ready;
  logic [31:0] a_req_data;
  logic [7:0]  a_tx_data;
  logic        a_tx_valid, a_tx_done, a_busy, a_err;
  logic [1:0]  a_grant;

  logic [3:0]  b_req_valid, b_req_ready;
  logic [31:0] b_req_data;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_done, b_busy, b_err;
  logic [1:0]  b_grant;

  logic [3:0]  c_req_valid, c_req_ready;
  logic [31:0] c_req_data;
  logic [7:0]  c_tx_data;
  logic        c_tx_valid, c_tx_done, c_busy, c_err;
  logic [1:0]  c_grant;

  uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(16), .TIMEOUT_CYCLES(1024)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_ready(a_req_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_done(a_tx_done), .grant_id(a_grant), .busy(a_busy), .err_timeout(a_err));

  uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(3), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_done(b_tx_done), .grant_id(b_grant), .busy(b_busy), .err_timeout(b_err));

  uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_data(c_req_data),
    .req_ready(c_req_ready), .tx_data(c_tx_data), .tx_valid(c_tx_valid),
    .tx_done(c_tx_done), .grant_id(c_grant), .busy(c_busy), .err_timeout(c_err));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard stop in case a wait loop is ever broken.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hold_ok;
    bit early;
    int exp_rr;
    int fair_seq [3];
    fair_seq = '{0, 1, 0};

    a_req_valid = '0; a_req_data = '0; a_tx_done = 1'b0;
    b_req_valid = '0; b_req_data = '0; b_tx_done = 1'b0;
    c_req_valid = '0; c_req_data = '0; c_tx_done = 1'b0;

    #1 rst = 1'b0;
    repeat (2) tick();
    check("rst_tx_valid", 32'(a_tx_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_ready", 32'(a_req_ready), 0);
    check("rst_grant", 32'(a_grant), 0);
    check("rst_data", 32'(a_tx_data), 0);
    check("rst_err", 32'(a_err), 0);
    rst = 1'b1;
    tick();

    // single request from requester 2, done 440 cycles into the frame
    a_req_data  = 32'h00A5_0000;
    a_req_valid = 4'b0100;
    tick();
    check("t1_ready", 32'(a_req_ready), 32'b0100);
    check("t1_tx_valid", 32'(a_tx_valid), 1);
    check("t1_tx_data", 32'(a_tx_data), 32'hA5);
    check("t1_grant", 32'(a_grant), 2);
    check("t1_busy", 32'(a_busy), 1);
    a_req_valid = '0;
    a_req_data  = 32'hFFFF_FFFF;
    hold_ok = 1'b1;
    repeat (439) begin
      tick();
      if (!(a_tx_valid && a_tx_data == 8'hA5 && a_req_ready == 4'b0000)) hold_ok = 1'b0;
    end
    check("t1_hold", 32'(hold_ok), 1);
    a_tx_done = 1'b1;
    tick();
    a_tx_done = 1'b0;
    check("t1_fall", 32'(a_tx_valid), 0);
    check("t1_gap_busy", 32'(a_busy), 1);
    check("t1_no_err", 32'(a_err), 0);

    // next request arrives during GAP; stray tx_done in GAP must not shorten it
    a_req_data  = 32'h0000_005C;
    a_req_valid = 4'b0001;
    n = 0;
    while (!a_tx_valid && n < 100) begin
      n++;
      a_tx_done = (n == 3);
      tick();
    end
    a_tx_done = 1'b0;
    check("t1_gap_len", 32'(n), 17);
    check("t2_grant", 32'(a_grant), 0);
    check("t2_ready", 32'(a_req_ready), 32'b0001);
    check("t2_data", 32'(a_tx_data), 32'h5C);

    // asynchronous reset in the middle of that frame
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(a_tx_valid), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_ready", 32'(a_req_ready), 0);
    check("mid_rst_err", 32'(a_err), 0);
    check("mid_rst_data", 32'(a_tx_data), 0);
    a_req_valid = '0;
    tick();
    tick();
    rst = 1'b1;

    // all requesters continuously valid: grants rotate from the reset pointer
    a_req_data  = 32'h1312_1110;
    a_req_valid = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      exp_rr = f % 4;
      n = 0;
      while (a_req_ready == 4'b0000 && n < 60) begin tick(); n++; end
      check("rr_ready", 32'(a_req_ready), 32'(1) << exp_rr);
      check("rr_grant", 32'(a_grant), 32'(exp_rr));
      check("rr_data", 32'(a_tx_data), 32'(16 + exp_rr));
      tick();
      check("rr_ready_pulse", 32'(a_req_ready), 0);
      repeat (98) tick();
      a_tx_done = 1'b1;
      tick();
      a_tx_done = 1'b0;
    end
    a_req_valid = '0;
    n = 0;
    while (a_busy && n < 60) begin tick(); n++; end
    check("rr_idle", 32'(a_busy), 0);

    // stray tx_done while idle
    a_tx_done = 1'b1;
    tick();
    a_tx_done = 1'b0;
    check("stray_idle_busy", 32'(a_busy), 0);
    check("stray_idle_tx_valid", 32'(a_tx_valid), 0);
    check("stray_idle_err", 32'(a_err), 0);
    check("stray_idle_ready", 32'(a_req_ready), 0);

    // last grant was 1, so pointer=2: requesters 0 and 1 get 0, 1, 0
    a_req_data  = 32'h0000_2120;
    a_req_valid = 4'b0011;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (a_req_ready == 4'b0000 && n < 60) begin tick(); n++; end
      check("fair_grant", 32'(a_grant), 32'(fair_seq[f]));
      check("fair_ready", 32'(a_req_ready), 32'(1) << fair_seq[f]);
      repeat (3) tick();
      a_tx_done = 1'b1;
      tick();
      a_tx_done = 1'b0;
    end
    a_req_valid = '0;

    // timeout: requester 1, tx_done never arrives
    b_req_data  = 32'h0000_3C00;
    b_req_valid = 4'b0010;
    n = 0;
    while (b_req_ready == 4'b0000 && n < 20) begin tick(); n++; end
    check("to_ready", 32'(b_req_ready), 32'b0010);
    check("to_grant", 32'(b_grant), 1);
    b_req_valid = '0;
    n = 0;
    early = 1'b0;
    while (b_tx_valid && n < 50) begin
      if (b_err) early = 1'b1;
      n++;
      tick();
    end
    check("to_len", 32'(n), 8);
    check("to_early_err", 32'(early), 0);
    check("to_err", 32'(b_err), 1);
    check("to_tx_valid", 32'(b_tx_valid), 0);
    check("to_gap_busy", 32'(b_busy), 1);
    b_req_data  = 32'h0000_005A;
    b_req_valid = 4'b0001;
    tick();
    check("to_err_once", 32'(b_err), 0);
    n = 0;
    while (!b_tx_valid && n < 50) begin n++; tick(); end
    check("to_gap_len", 32'(n + 1), 4);
    check("to_next_grant", 32'(b_grant), 0);
    check("to_next_data", 32'(b_tx_data), 32'h5A);
    b_req_valid = '0;

    // tx_done on the 8th SEND cycle collides with the timeout: no error
    repeat (7) tick();
    check("col_still_valid", 32'(b_tx_valid), 1);
    b_tx_done = 1'b1;
    tick();
    b_tx_done = 1'b0;
    check("col_tx_valid", 32'(b_tx_valid), 0);
    check("col_err", 32'(b_err), 0);
    tick();
    check("col_err_after", 32'(b_err), 0);

    // zero gap: back-to-back frames with one low cycle between them
    c_req_data  = 32'h00C2_00C0;
    c_req_valid = 4'b0101;
    n = 0;
    while (c_req_ready == 4'b0000 && n < 20) begin tick(); n++; end
    check("g0_grant0", 32'(c_grant), 0);
    check("g0_data0", 32'(c_tx_data), 32'hC0);
    repeat (2) tick();
    c_tx_done = 1'b1;
    tick();
    c_tx_done = 1'b0;
    check("g0_low", 32'(c_tx_valid), 0);
    check("g0_idle", 32'(c_busy), 0);
    n = 0;
    while (!c_tx_valid && n < 20) begin n++; tick(); end
    check("g0_low_len", 32'(n), 1);
    check("g0_grant1", 32'(c_grant), 2);
    check("g0_ready1", 32'(c_req_ready), 32'b0100);
    check("g0_data1", 32'(c_tx_data), 32'hC2);
    c_req_valid = '0;
    c_tx_done = 1'b1;
    tick();
    c_tx_done = 1'b0;
    check("g0_err", 32'(c_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
